// File: rtl/core_bus_pkg.sv
// Shared types and constants for the arm810 core-bus to Avalon-MM bridge.
package core_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CMD   = 2'd1,
      ST_RDATA = 2'd2,
      ST_DONE  = 2'd3
   } core_bus_state_t;

   typedef logic [31:0] word_t;
   typedef logic [29:0] word_addr_t;

   localparam logic [3:0] AVL_BE_ALL = 4'hF;

endpackage

// File: rtl/core_bus_avl_bridge_if.sv
// Core-bus request/completion signals plus the Avalon-MM master port of the bridge.
interface core_bus_avl_bridge_if;
   import core_bus_pkg::*;

   // Core side: bus_start is a one-cycle request strobe that qualifies addr/write/data_wr;
   // bus_ready is a one-cycle completion pulse that qualifies data_rd and fault.
   // Avalon side: a command is accepted in the cycle avl_waitrequest is low while
   // avl_read/avl_write is high; avl_readdatavalid qualifies avl_readdata.
   word_addr_t bus_addr;
   logic       bus_write;
   word_t      bus_data_wr;
   logic       bus_start;
   logic       bus_ready;
   word_t      bus_data_rd;
   logic       bus_fault;

   word_t      avl_address;
   logic       avl_read;
   logic       avl_write;
   word_t      avl_writedata;
   logic [3:0] avl_byteenable;
   logic       avl_waitrequest;
   word_t      avl_readdata;
   logic       avl_readdatavalid;

   modport slave (
      input  bus_addr, bus_write, bus_data_wr, bus_start,
      output bus_ready, bus_data_rd, bus_fault,
      output avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
      input  avl_waitrequest, avl_readdata, avl_readdatavalid
   );

   modport master (
      output bus_addr, bus_write, bus_data_wr, bus_start,
      input  bus_ready, bus_data_rd, bus_fault,
      input  avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
      output avl_waitrequest, avl_readdata, avl_readdatavalid
   );

endinterface

// File: rtl/core_bus_avl_bridge.sv
// Translates each core-bus transaction into one Avalon-MM access, with a read-response
// timeout that faults the core transaction and discards the late response.
module core_bus_avl_bridge
   import core_bus_pkg::*;
#(
   parameter int TIMEOUT = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   core_bus_avl_bridge_if.slave bus,
   output core_bus_state_t      dbg_state
);

   localparam int            CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT);
   localparam bit            TO_EN   = (TIMEOUT > 0);

   core_bus_state_t state_q, state_d;
   logic            cmd_rd_q, cmd_rd_d;
   logic            cmd_wr_q, cmd_wr_d;
   logic            ready_q, ready_d;
   logic            fault_q, fault_d;
   word_t           rdata_q, rdata_d;
   logic            drop_q, drop_d;
   logic            pend_q, pend_d;
   word_addr_t      addr_q, addr_d;
   word_t           wdata_q, wdata_d;
   logic            is_write_q, is_write_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            go;
   logic            go_write;

   always_comb begin
      state_d    = state_q;
      cmd_rd_d   = cmd_rd_q;
      cmd_wr_d   = cmd_wr_q;
      ready_d    = 1'b0;
      fault_d    = 1'b0;
      rdata_d    = rdata_q;
      drop_d     = drop_q;
      pend_d     = pend_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      is_write_d = is_write_q;
      cnt_d      = '0;
      go         = 1'b0;
      go_write   = 1'b0;

      // Any response while a drop is owed belongs to the timed-out read.
      if (bus.avl_readdatavalid) drop_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.bus_start && !pend_q) begin
               addr_d     = bus.bus_addr;
               wdata_d    = bus.bus_data_wr;
               is_write_d = bus.bus_write;
            end
            go       = bus.bus_start || pend_q;
            go_write = pend_q ? is_write_q : bus.bus_write;
            if (go) begin
               if (drop_q && !bus.avl_readdatavalid) begin
                  pend_d = 1'b1;
               end else begin
                  pend_d   = 1'b0;
                  cmd_wr_d = go_write;
                  cmd_rd_d = !go_write;
                  state_d  = ST_CMD;
               end
            end
         end
         ST_CMD: begin
            if (!bus.avl_waitrequest) begin
               cmd_rd_d = 1'b0;
               cmd_wr_d = 1'b0;
               if (is_write_q) begin
                  ready_d = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RDATA;
               end
            end
         end
         ST_RDATA: begin
            if (bus.avl_readdatavalid) begin
               rdata_d = bus.avl_readdata;
               ready_d = 1'b1;
               state_d = ST_DONE;
            end else if (TO_EN && cnt_q == TO_LAST) begin
               rdata_d = '0;
               fault_d = 1'b1;
               ready_d = 1'b1;
               drop_d  = 1'b1;
               state_d = ST_DONE;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               cnt_d = cnt_q;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cmd_rd_q   <= 1'b0;
         cmd_wr_q   <= 1'b0;
         ready_q    <= 1'b0;
         fault_q    <= 1'b0;
         rdata_q    <= '0;
         drop_q     <= 1'b0;
         pend_q     <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         is_write_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         cmd_rd_q   <= cmd_rd_d;
         cmd_wr_q   <= cmd_wr_d;
         ready_q    <= ready_d;
         fault_q    <= fault_d;
         rdata_q    <= rdata_d;
         drop_q     <= drop_d;
         pend_q     <= pend_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         is_write_q <= is_write_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.bus_ready      = ready_q;
   assign bus.bus_fault      = fault_q;
   assign bus.bus_data_rd    = rdata_q;
   assign bus.avl_address    = {addr_q, 2'b00};
   assign bus.avl_read       = cmd_rd_q;
   assign bus.avl_write      = cmd_wr_q;
   assign bus.avl_writedata  = wdata_q;
   assign bus.avl_byteenable = AVL_BE_ALL;
   assign dbg_state          = state_q;

   // A new request while a transaction is in flight is dropped by the FSM.
   start_only_when_idle: assert property (@(posedge clk) disable iff (rst)
      !(bus.bus_start && state_q != ST_IDLE));

endmodule
